// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side (master) issues operations and reads HI/LO; the unit
// (slave) reports busy/done and presents its architectural registers.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             read_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hilo_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush, read_hi,
    input  busy, done, hilo_out, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush, read_hi,
    output busy, done, hilo_out, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies use radix-2 shift-add, divides use restoring shift-subtract,
// both on operand magnitudes; signs are restored in a final FIX cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               start_md;

  // Iteration datapath: acc_hi:acc_lo is the product / remainder:quotient pair
  logic [WIDTH-1:0]   acc_hi, acc_lo, opb, rs_orig;
  logic               is_div, neg_q, neg_r, div0;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Two's-complement magnitude; the most-negative value maps to itself,
  // which is exactly its unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign accept   = (state == IDLE) && bus.start && !bus.flush;
  assign start_md = accept && !bus.op[2];

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_md)
        cnt <= '0;
      else if (state == RUN)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state: WIDTH iterations in RUN, one FIX cycle, flush aborts anywhere busy
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_md) state_nxt = RUN;
      RUN: begin
        if (bus.flush)
          state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))
          state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add / shift-subtract step and the sign-corrected results
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = cond_neg2({acc_hi, acc_lo}, neg_q);
    quo_fix   = cond_neg(acc_lo, neg_q);
    rem_fix   = cond_neg(acc_hi, neg_r);
  end

  // Operand capture at issue, then one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (start_md) begin
      is_div  <= bus.op[1];
      acc_hi  <= '0;
      acc_lo  <= bus.op[0] ? mag(bus.rs_data) : bus.rs_data;
      opb     <= bus.op[0] ? mag(bus.rt_data) : bus.rt_data;
      neg_q   <= bus.op[0] & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
      neg_r   <= bus.op[0] & bus.rs_data[WIDTH-1];
      div0    <= (bus.rt_data == '0);
      rs_orig <= bus.rs_data;
    end else if (state == RUN) begin
      if (!is_div) begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
        acc_hi <= div_diff[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi <= div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Architectural HI/LO: MTHI/MTLO writes at issue, mult/div results at FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && bus.op == 3'b100)
        hi_q <= bus.rs_data;
      if (accept && bus.op == 3'b101)
        lo_q <= bus.rs_data;
      if (state == FIX && !bus.flush) begin
        done_q <= 1'b1;
        if (!is_div) begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end else if (div0) begin
          hi_q <= rs_orig;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.hilo_out = bus.read_hi ? hi_q : lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the EX stage. Asserts busy to stall the pipeline while an operation runs. Its hilo_out result feeds the 32-bit writeback select mux alongside the ALU and memory data.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe; sampled only when busy=0
op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
rs_data  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
rt_data  input  WIDTH  multiplier / divisor
flush  input  1  cancels an in-flight operation (branch/exception squash)
read_hi  input  1  1 -> hilo_out=HI, 0 -> hilo_out=LO (MFHI/MFLO)
busy  output  1  high while a mult/div is in progress
done  output  1  one-cycle pulse after HI/LO are updated by a mult/div
hilo_out  output  WIDTH  combinational read of HI or LO
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset overrides all other inputs, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MULT*/DIV*: latch operands at edge E0. Signed ops latch magnitudes and record the result signs. Unsigned ops latch raw values. Counter=0, go to RUN, busy=1 from E0.
- IDLE, start=1, op=MTHI/MTLO: write rs_data into HI/LO at E0. Stay IDLE, busy stays 0, done stays 0.
- IDLE, start=1, op=11x: no effect.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle at E1..E_WIDTH. After E_WIDTH go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply sign correction.
  - Write HI/LO: multiply gives HI=product[2W-1:W], LO=product[W-1:0]; divide gives LO=quotient, HI=remainder.
  - busy=0 and done=1 for exactly one cycle. Return to IDLE.
  - Latency from the start edge to HI/LO valid is WIDTH+1 edges (33 at default).
- Sign rules:
  - MULT: product negated if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): LO=all ones, HI=rs_data (original signed value). Same latency.
- Signed overflow (DIV of most-negative value by -1): LO=most-negative value, HI=0.
- start while busy=1: ignored, including MTHI/MTLO. The pipeline must hold the instruction, since it sees busy.
- flush while busy=1: at that edge go to IDLE, busy=0, no done pulse, HI/LO unchanged.
- flush in IDLE with start=1: the start is ignored.
- A new start is accepted in the cycle done=1, since busy=0 then.
- hilo_out: purely combinational from read_hi and the current HI/LO. During RUN it returns the old values.

Test Plan:
- MULTU rs=FFFFFFFF, rt=FFFFFFFF -> busy high for 33 cycles, done pulse, HI=FFFFFFFE, LO=00000001.
- MULT rs=FFFFFFFD (-3), rt=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB. Then DIV rs=FFFFFFF9 (-7), rt=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIV rs=80000000, rt=FFFFFFFF -> LO=80000000, HI=00000000. DIVU rs=12345678, rt=0 -> LO=FFFFFFFF, HI=12345678, still 33 cycles.
- MTHI rs=AAAA5555 then MTLO rs=0000BEEF in consecutive cycles -> busy never rises, hi=AAAA5555, lo=0000BEEF. hilo_out follows read_hi the same cycle.
- Start MULTU, issue start(MTLO) at cycle 5 -> ignored. Assert flush at cycle 10 -> busy=0 next cycle, no done, HI/LO keep their prior values.
- Start DIVU, assert reset at cycle 20 -> next edge busy=0, done=0, hi=lo=0. A new MULTU issued right after reset completes correctly.
